// File: rtl/wr_burst_ctrl.sv
// DDR4 frame-buffer write burst sequencer.
// Double-buffered: writes one buffer while the other is readable.
module wr_burst_ctrl #(
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned FRAME_BURSTS = 2025,
  parameter logic [28:0] BUF0_ADDR    = 29'h0000000,
  parameter logic [28:0] BUF1_ADDR    = 29'h1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_calib_complete,
  input  logic        frame_start,
  input  logic [9:0]  fifo_rd_count,
  input  logic        wr_end,
  output logic        wr_cmd_start,
  output logic [28:0] wr_cmd_addr,
  output logic [7:0]  wr_cmd_bl,
  output logic [2:0]  wr_cmd_intr,
  output logic [63:0] wr_cmd_mask,
  output logic        rd_buf_sel,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    START,
    WAIT_END,
    NEXT
  } state_t;

  localparam logic [28:0] STEP   = 29'(BURST_LEN * 8);
  localparam logic [15:0] LAST   = 16'(FRAME_BURSTS - 1);
  localparam logic [9:0]  THRESH = 10'(BURST_LEN);

  state_t      state;
  logic [15:0] burst_cnt;
  logic        pend;
  logic [28:0] wr_base;
  logic [28:0] nxt_base;

  // wr_base: buffer not shown to readers; nxt_base: same after a toggle
  assign wr_base  = rd_buf_sel ? BUF0_ADDR : BUF1_ADDR;
  assign nxt_base = rd_buf_sel ? BUF1_ADDR : BUF0_ADDR;

  assign wr_cmd_bl   = 8'(BURST_LEN);
  assign wr_cmd_intr = 3'b000;
  assign wr_cmd_mask = 64'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_cmd_start <= 1'b0;
      wr_cmd_addr  <= BUF0_ADDR;
      rd_buf_sel   <= 1'b1;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
      burst_cnt    <= 16'd0;
      pend         <= 1'b0;
    end else begin
      wr_cmd_start <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (init_calib_complete && frame_start) begin
            wr_cmd_addr <= wr_base;
            burst_cnt   <= 16'd0;
            pend        <= 1'b0;
            busy        <= 1'b1;
            state       <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (pend) begin
            frame_err   <= 1'b1;
            wr_cmd_addr <= wr_base;
            burst_cnt   <= 16'd0;
            pend        <= frame_start;
          end else begin
            pend <= frame_start;
            if (fifo_rd_count >= THRESH) begin
              wr_cmd_start <= 1'b1;
              state        <= START;
            end
          end
        end
        START: begin
          if (frame_start) pend <= 1'b1;
          state <= WAIT_END;
        end
        WAIT_END: begin
          if (frame_start) pend <= 1'b1;
          if (wr_end) state <= NEXT;
        end
        NEXT: begin
          state <= WAIT_DATA;
          if (pend) begin
            frame_err   <= 1'b1;
            wr_cmd_addr <= wr_base;
            burst_cnt   <= 16'd0;
            pend        <= frame_start;
          end else if (burst_cnt == LAST) begin
            rd_buf_sel <= ~rd_buf_sel;
            frame_done <= 1'b1;
            burst_cnt  <= 16'd0;
            // a vsync landing here starts the next frame with no gap
            if (frame_start) begin
              wr_cmd_addr <= nxt_base;
            end else begin
              wr_cmd_addr <= wr_cmd_addr + STEP;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            wr_cmd_addr <= wr_cmd_addr + STEP;
            burst_cnt   <= burst_cnt + 16'd1;
            pend        <= frame_start;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Bench for wr_burst_ctrl: vector table plus scoreboarded
// burst/frame event sequences.
module tb_wr_burst_ctrl;

  localparam int BL = 64;
  localparam int FB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_calib_complete = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  fifo_rd_count = 10'd0;
  logic        wr_end = 1'b0;
  logic        wr_cmd_start;
  logic [28:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_bl;
  logic [2:0]  wr_cmd_intr;
  logic [63:0] wr_cmd_mask;
  logic        rd_buf_sel;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  wr_burst_ctrl #(
    .BURST_LEN(BL),
    .FRAME_BURSTS(FB),
    .BUF0_ADDR(29'h0000000),
    .BUF1_ADDR(29'h1000000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .init_calib_complete(init_calib_complete),
    .frame_start(frame_start),
    .fifo_rd_count(fifo_rd_count),
    .wr_end(wr_end),
    .wr_cmd_start(wr_cmd_start),
    .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_bl(wr_cmd_bl),
    .wr_cmd_intr(wr_cmd_intr),
    .wr_cmd_mask(wr_cmd_mask),
    .rd_buf_sel(rd_buf_sel),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  typedef enum logic [1:0] {EV_START, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e         kind;
    logic [28:0] val;
  } ev_t;
  ev_t sbq[$];

  typedef struct {
    logic        calib;
    logic        fs;
    logic [9:0]  fifo;
    logic        we;
    logic        x_start;
    logic        x_busy;
    logic [28:0] x_addr;
  } vec_t;
  vec_t vecs[13];

  task automatic expect_ev(input ev_e k, input logic [28:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input ev_e k, input logic [28:0] v,
                        input string nm);
    ev_t e;
    ncmp++;
    if (sbq.size() == 0) begin
      nfail++;
      $display("FAIL %s: unexpected event kind %0d val %0h",
               nm, k, v);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.val !== v) begin
        nfail++;
        $display("FAIL %s: got kind %0d val %0h want kind %0d val %0h",
                 nm, k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_cmd_start) sb_pop(EV_START, wr_cmd_addr, "start_addr");
      if (frame_done) sb_pop(EV_DONE, 29'(rd_buf_sel), "done_sel");
      if (frame_err) sb_pop(EV_ERR, 29'(rd_buf_sel), "err_sel");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (wr_cmd_start) seen = 1'b1;
    end
    chk("start_seen", 64'(seen), 64'd1);
  endtask

  // wr_end five cycles after the start; optional vsync with it or one later
  task automatic finish_burst(input bit fs_with, input bit fs_after);
    repeat (4) tick();
    wr_end = 1'b1;
    frame_start = fs_with;
    tick();
    wr_end = 1'b0;
    frame_start = fs_after;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_burst(input bit fs_with, input bit fs_after);
    wait_start();
    finish_burst(fs_with, fs_after);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    //           calib fs  fifo    we   start busy addr
    vecs[0]  = '{1'b0, 1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 29'h0};
    vecs[1]  = '{1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 29'h0};
    vecs[2]  = '{1'b1, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 29'h0};
    vecs[3]  = '{1'b1, 1'b1, 10'd63, 1'b0, 1'b0, 1'b1, 29'h0};
    vecs[4]  = '{1'b1, 1'b0, 10'd63, 1'b0, 1'b0, 1'b1, 29'h0};
    vecs[5]  = '{1'b1, 1'b0, 10'd63, 1'b0, 1'b0, 1'b1, 29'h0};
    vecs[6]  = '{1'b1, 1'b0, 10'd64, 1'b0, 1'b1, 1'b1, 29'h0};
    vecs[7]  = '{1'b1, 1'b0, 10'd64, 1'b0, 1'b0, 1'b1, 29'h0};
    vecs[8]  = '{1'b1, 1'b0, 10'd64, 1'b0, 1'b0, 1'b1, 29'h0};
    vecs[9]  = '{1'b1, 1'b0, 10'd64, 1'b1, 1'b0, 1'b1, 29'h0};
    vecs[10] = '{1'b1, 1'b0, 10'd64, 1'b1, 1'b0, 1'b1, 29'h0};
    vecs[11] = '{1'b1, 1'b0, 10'd64, 1'b0, 1'b1, 1'b1, 29'h200};
    vecs[12] = '{1'b1, 1'b0, 10'd64, 1'b0, 1'b0, 1'b1, 29'h0};

    repeat (3) tick();
    chk("rst_start", 64'(wr_cmd_start), 64'd0);
    chk("rst_addr", 64'(wr_cmd_addr), 64'h0);
    chk("rst_sel", 64'(rd_buf_sel), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("cmd_bl", 64'(wr_cmd_bl), 64'd64);
    chk("cmd_intr", 64'(wr_cmd_intr), 64'd0);
    chk("cmd_mask", wr_cmd_mask, 64'd0);
    rst_n = 1'b1;
    tick();

    // calibration gate, FIFO threshold, first two bursts
    foreach (vecs[i]) begin
      init_calib_complete = vecs[i].calib;
      frame_start = vecs[i].fs;
      fifo_rd_count = vecs[i].fifo;
      wr_end = vecs[i].we;
      if (vecs[i].x_start) expect_ev(EV_START, vecs[i].x_addr);
      tick();
      chk($sformatf("vec%0d_start", i), 64'(wr_cmd_start),
          64'(vecs[i].x_start));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].x_busy));
      if (vecs[i].x_start)
        chk($sformatf("vec%0d_addr", i), 64'(wr_cmd_addr),
            64'(vecs[i].x_addr));
    end
    frame_start = 1'b0;
    wr_end = 1'b0;

    // finish frame 1 on buffer 0
    expect_ev(EV_START, 29'h400);
    expect_ev(EV_DONE, 29'd0);
    finish_burst(1'b0, 1'b0);
    do_burst(1'b0, 1'b0);
    repeat (3) tick();
    chk("f1_busy", 64'(busy), 64'd0);
    chk("f1_sel", 64'(rd_buf_sel), 64'd0);

    // frame 2 on buffer 1
    expect_ev(EV_START, 29'h1000000);
    expect_ev(EV_START, 29'h1000200);
    expect_ev(EV_START, 29'h1000400);
    expect_ev(EV_DONE, 29'd1);
    pulse_fs();
    repeat (3) do_burst(1'b0, 1'b0);
    repeat (3) tick();
    chk("f2_sel", 64'(rd_buf_sel), 64'd1);

    // vsync during WAIT_END of burst 1 restarts buffer 0
    expect_ev(EV_START, 29'h0);
    pulse_fs();
    do_burst(1'b0, 1'b0);
    expect_ev(EV_START, 29'h200);
    expect_ev(EV_ERR, 29'd1);
    expect_ev(EV_START, 29'h0);
    expect_ev(EV_START, 29'h200);
    expect_ev(EV_START, 29'h400);
    expect_ev(EV_DONE, 29'd0);
    wait_start();
    tick();
    pulse_fs();
    finish_burst(1'b0, 1'b0);
    chk("rs_sel", 64'(rd_buf_sel), 64'd1);
    repeat (3) do_burst(1'b0, 1'b0);
    repeat (3) tick();
    chk("rs_done_sel", 64'(rd_buf_sel), 64'd0);

    // vsync in the final NEXT chains straight into the next frame
    expect_ev(EV_START, 29'h1000000);
    expect_ev(EV_START, 29'h1000200);
    expect_ev(EV_START, 29'h1000400);
    expect_ev(EV_DONE, 29'd1);
    expect_ev(EV_START, 29'h0);
    expect_ev(EV_START, 29'h200);
    expect_ev(EV_START, 29'h400);
    expect_ev(EV_DONE, 29'd0);
    pulse_fs();
    do_burst(1'b0, 1'b0);
    do_burst(1'b0, 1'b0);
    do_burst(1'b0, 1'b1);
    chk("chain_busy", 64'(busy), 64'd1);
    chk("chain_sel", 64'(rd_buf_sel), 64'd1);
    repeat (3) do_burst(1'b0, 1'b0);
    repeat (3) tick();
    chk("chain_idle", 64'(busy), 64'd0);
    chk("chain_sel2", 64'(rd_buf_sel), 64'd0);

    // wr_end and vsync together: burst counted, then restart
    expect_ev(EV_START, 29'h1000000);
    expect_ev(EV_START, 29'h1000200);
    expect_ev(EV_ERR, 29'd0);
    expect_ev(EV_START, 29'h1000000);
    pulse_fs();
    do_burst(1'b0, 1'b0);
    do_burst(1'b1, 1'b0);
    wait_start();
    tick();

    // reset while waiting for wr_end
    rst_n = 1'b0;
    #1;
    chk("mr_start", 64'(wr_cmd_start), 64'd0);
    chk("mr_addr", 64'(wr_cmd_addr), 64'h0);
    chk("mr_sel", 64'(rd_buf_sel), 64'd1);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(frame_done), 64'd0);
    chk("mr_err", 64'(frame_err), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    repeat (5) tick();
    chk("late_end_busy", 64'(busy), 64'd0);
    chk("late_end_sel", 64'(rd_buf_sel), 64'd1);

    // first frame after reset goes to buffer 0
    expect_ev(EV_START, 29'h0);
    expect_ev(EV_START, 29'h200);
    expect_ev(EV_START, 29'h400);
    expect_ev(EV_DONE, 29'd0);
    pulse_fs();
    repeat (3) do_burst(1'b0, 1'b0);
    repeat (3) tick();
    chk("post_rst_sel", 64'(rd_buf_sel), 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/wr_burst_ctrl.md
WR_BURST_CTRL -- requirements
Module: wr_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64: 512-bit beats per burst; legal range 1..255.
REQ-002 SHALL have parameter FRAME_BURSTS, default 2025: bursts per frame (1920x1080, 32 bpp); legal range 1..65535.
REQ-003 SHALL have parameter BUF0_ADDR, default 29'h0000000: base address of frame buffer 0.
REQ-004 SHALL have parameter BUF1_ADDR, default 29'h1000000: base address of frame buffer 1.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk input 1, the DDR4 UI clock; rst_n input 1, async active-low reset.
REQ-006 SHALL have port init_calib_complete, input, 1 bit: DDR4 calibration done, level.
REQ-007 SHALL have port frame_start, input, 1 bit: one-cycle pulse at source vsync.
REQ-008 SHALL have port fifo_rd_count, input, 10 bits: 512-bit words available in the write FIFO.
REQ-009 SHALL have port wr_end, input, 1 bit: one-cycle pulse from the downstream write stage when a burst completes.
REQ-010 SHALL have port wr_cmd_start, output, 1 bit: one-cycle burst request.
REQ-011 SHALL have port wr_cmd_addr, output, 29 bits: burst start address.
REQ-012 SHALL have port wr_cmd_bl, output, 8 bits: burst length, constant BURST_LEN.
REQ-013 SHALL have port wr_cmd_intr, output, 3 bits: constant 3'b000 (write).
REQ-014 SHALL have port wr_cmd_mask, output, 64 bits: constant 64'h0.
REQ-015 SHALL have port rd_buf_sel, output, 1 bit: index of the last completely written buffer.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-017 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is abandoned.
REQ-018 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_DATA, START, WAIT_END, NEXT; all outputs registered.
REQ-020 IDLE: SHALL remain until init_calib_complete=1 and frame_start=1, then load addr=base of wr_buf (the buffer not equal to rd_buf_sel), clear burst_cnt, and go to WAIT_DATA.
REQ-021 WAIT_DATA: SHALL go to START on the cycle after fifo_rd_count >= BURST_LEN is sampled.
REQ-022 START: SHALL assert wr_cmd_start for exactly one cycle, then go to WAIT_END.
REQ-023 wr_cmd_addr SHALL be stable from the START cycle until wr_end is sampled.
REQ-024 WAIT_END: SHALL wait for wr_end with no timeout, then go to NEXT.
REQ-025 NEXT: SHALL set addr = addr + BURST_LEN*8, modulo 2^29 (wraps silently).
REQ-025a NEXT, when burst_cnt = FRAME_BURSTS-1: SHALL toggle rd_buf_sel, pulse frame_done, and go to IDLE.
REQ-025b NEXT, otherwise: SHALL set burst_cnt+1 and go to WAIT_DATA.
REQ-026 burst_cnt SHALL be 16 bits; address arithmetic SHALL be 29 bits.
REQ-027 frame_start in WAIT_DATA, START, WAIT_END or NEXT SHALL set a pending flag.
REQ-027a An in-flight burst (START/WAIT_END) SHALL complete normally on the pending flag; it is never aborted.
REQ-028 On reaching NEXT or WAIT_DATA with the flag set, the block SHALL:
 - pulse frame_err;
 - not toggle rd_buf_sel;
 - reload addr to the same wr_buf base;
 - clear burst_cnt and the flag;
 - go to WAIT_DATA.
REQ-029 wr_end and frame_start in the same cycle SHALL apply both: the burst is counted, then the REQ-028 restart is taken.
REQ-030 frame_start coinciding with the final NEXT SHALL:
 - complete the frame (frame_done, rd_buf_sel toggles);
 - arm the new frame directly into WAIT_DATA on the new wr_buf;
 - not pulse frame_err.
REQ-031 init_calib_complete falling SHALL affect only the IDLE entry condition; a frame in progress continues.
REQ-032 wr_end outside WAIT_END SHALL be ignored.

Reset
REQ-033 While rst_n=0, outputs SHALL take these values:
 - state=IDLE;
 - wr_cmd_start=0, wr_cmd_addr=BUF0_ADDR;
 - rd_buf_sel=1, so the first frame writes buffer 0;
 - frame_done=0, frame_err=0, busy=0;
 - burst_cnt=0, pending flag cleared.
REQ-034 Reset mid-burst SHALL abandon all state immediately; no completion pulse SHALL follow.

Verification
REQ-035 Calibration gate: init_calib_complete=0, frame_start pulse -> no wr_cmd_start; calibrate, pulse again -> wr_cmd_start with addr 0x0000000.
REQ-036 Burst sequence: FRAME_BURSTS=3, BURST_LEN=64, FIFO count held at 64, wr_end 5 cycles after each start -> addresses 0x0, 0x200, 0x400, then frame_done and rd_buf_sel=0.
REQ-037 Second frame: frame_start after REQ-036 -> first address 0x1000000; at end rd_buf_sel=1.
REQ-038 FIFO threshold: fifo_rd_count=63 -> no start; raise to 64 -> wr_cmd_start on the following cycle.
REQ-039 Mid-frame restart: frame_start during WAIT_END of burst 1 -> burst completes, then frame_err, next address 0x0, rd_buf_sel unchanged.
REQ-040 Reset mid-burst: rst_n low in WAIT_END -> outputs at reset values; late wr_end ignored.
